// File: rtl/mux_scan_n_1_pkg.sv
// -----------------------------------------------------------------------------
// mux_scan_pkg
// Shared types and constants for the mux_scan_n_1 block.
//   state_t     : FSM state encoding (IDLE, DIRECT, SCAN)
//   MODE_DIRECT : i_mode value selecting direct channel select
//   MODE_SCAN   : i_mode value selecting autonomous masked scan
// -----------------------------------------------------------------------------
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_scan_n_1_if.sv
// -----------------------------------------------------------------------------
// mux_scan_n_1_if
// Bus bundle between a multi-channel source/controller and mux_scan_n_1.
// Parameters: N_CH (channels), DW (bits per channel).
//   i_en    : block enable
//   i_mode  : 0 = direct select, 1 = scan
//   i_data  : N_CH*DW packed channels, channel k at [k*DW +: DW]
//   i_sel   : direct-mode channel index
//   i_mask  : scan-eligible channels
//   o_data  : selected channel data (registered)
//   o_sel   : index of the channel on o_data
//   o_valid : o_data/o_sel meaningful
//   o_wrap  : one-cycle pulse on scan pointer wrap
// Modports: master drives the i_* side, slave (the mux) drives the o_* side.
// -----------------------------------------------------------------------------
interface mux_scan_n_1_if #(
    parameter int N_CH = 8,
    parameter int DW   = 1
);
    localparam int SEL_W = $clog2(N_CH);

    logic                 i_en;
    logic                 i_mode;
    logic [N_CH*DW-1:0]   i_data;
    logic [SEL_W-1:0]     i_sel;
    logic [N_CH-1:0]      i_mask;
    logic [DW-1:0]        o_data;
    logic [SEL_W-1:0]     o_sel;
    logic                 o_valid;
    logic                 o_wrap;

    modport master (
        output i_en, i_mode, i_data, i_sel, i_mask,
        input  o_data, o_sel, o_valid, o_wrap
    );

    modport slave (
        input  i_en, i_mode, i_data, i_sel, i_mask,
        output o_data, o_sel, o_valid, o_wrap
    );

endinterface

// File: rtl/mux_scan_n_1_next_ch.sv
// -----------------------------------------------------------------------------
// mux_scan_next_ch
// Combinational circular search for the next set bit of a channel mask.
//   i_mask    : candidate channels
//   i_start   : index the search is anchored at
//   i_incl    : 1 = i_start itself is a candidate, 0 = search strictly after it
//   o_next    : index of the first set bit found (0 when none)
//   o_found   : at least one mask bit is set
//   o_wrapped : the search went past the top index back to/below i_start
// -----------------------------------------------------------------------------
module mux_scan_next_ch #(
    parameter int N_CH  = 8,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  i_mask,
    input  logic [SEL_W-1:0] i_start,
    input  logic             i_incl,
    output logic [SEL_W-1:0] o_next,
    output logic             o_found,
    output logic             o_wrapped
);

    logic [SEL_W-1:0] w_base;
    logic [SEL_W-1:0] w_idx;

    // N_CH is a power of two, so SEL_W-bit addition wraps the index circularly.
    always_comb begin
        w_base  = i_incl ? i_start : i_start + SEL_W'(1);
        w_idx   = '0;
        o_next  = '0;
        o_found = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            w_idx = w_base + SEL_W'(i);
            if (!o_found && i_mask[w_idx]) begin
                o_next  = w_idx;
                o_found = 1'b1;
            end
        end
    end

    // A strict search that lands on i_start itself (single-bit mask) counts as a wrap.
    assign o_wrapped = o_found && (i_incl ? (o_next < i_start) : (o_next <= i_start));

endmodule

// File: rtl/mux_scan_n_1.sv
// -----------------------------------------------------------------------------
// mux_scan_n_1
// Registered N:1 multiplexer with enable and an autonomous masked scan mode.
// Parameters: N_CH (channels, power of two >= 2), DW (bits per channel),
//             DWELL (cycles each channel is shown in scan mode, >= 1).
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : mux_scan_n_1_if.slave (i_en, i_mode, i_data, i_sel, i_mask in;
//             o_data, o_sel, o_valid, o_wrap out)
// Build option: MUX_SCAN_HOLD_EN -- when defined, o_data keeps its last value
// while disabled; otherwise it is cleared on the first disabled edge.
// -----------------------------------------------------------------------------
module mux_scan_n_1 #(
    parameter int N_CH  = 8,
    parameter int DW    = 1,
    parameter int DWELL = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    mux_scan_n_1_if.slave   bus
);
    import mux_scan_pkg::*;

    localparam int SEL_W = $clog2(N_CH);
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    state_t           r_state;
    logic [SEL_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_scan_act;
    logic [DW-1:0]    r_data;
    logic [SEL_W-1:0] r_sel;
    logic             r_valid;
    logic             r_wrap;

    logic             w_entry;
    logic             w_term;
    logic [SEL_W-1:0] w_start;
    logic [SEL_W-1:0] w_next;
    logic             w_found;
    logic             w_wrapped;

    function automatic logic [DW-1:0] ch_data(input logic [N_CH*DW-1:0] data,
                                              input logic [SEL_W-1:0]   k);
        return data[k*DW +: DW];
    endfunction

    // A scan (re)starts when coming from IDLE/DIRECT, or when the previous
    // scan cycle had an empty mask and therefore no channel on display.
    assign w_entry = (r_state != SCAN) || !r_scan_act;
    assign w_term  = (r_cnt == CNT_W'(DWELL - 1));
    assign w_start = w_entry ? '0 : r_ptr;

    // Single search shared by entry (inclusive from 0) and advance (strictly after ptr).
    mux_scan_next_ch #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_next_ch (
        .i_mask    (bus.i_mask),
        .i_start   (w_start),
        .i_incl    (w_entry),
        .o_next    (w_next),
        .o_found   (w_found),
        .o_wrapped (w_wrapped)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_scan_act <= 1'b0;
            r_data     <= '0;
            r_sel      <= '0;
            r_valid    <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (!bus.i_en) begin
                r_state    <= IDLE;
                r_valid    <= 1'b0;
                r_scan_act <= 1'b0;
`ifdef MUX_SCAN_HOLD_EN
                r_data     <= r_data;
`else
                r_data     <= '0;
`endif
            end else if (bus.i_mode == MODE_DIRECT) begin
                r_state    <= DIRECT;
                r_scan_act <= 1'b0;
                r_data     <= ch_data(bus.i_data, bus.i_sel);
                r_sel      <= bus.i_sel;
                r_valid    <= 1'b1;
            end else begin
                r_state <= SCAN;
                if (!w_found) begin
                    // Empty mask: nothing to show; ptr, count and data hold.
                    r_valid    <= 1'b0;
                    r_scan_act <= 1'b0;
                end else if (w_entry) begin
                    r_ptr      <= w_next;
                    r_cnt      <= '0;
                    r_scan_act <= 1'b1;
                    r_data     <= ch_data(bus.i_data, w_next);
                    r_sel      <= w_next;
                    r_valid    <= 1'b1;
                end else if (w_term) begin
                    // Mask is only consulted here, so a channel removed
                    // mid-dwell still finishes its dwell.
                    r_ptr   <= w_next;
                    r_cnt   <= '0;
                    r_data  <= ch_data(bus.i_data, w_next);
                    r_sel   <= w_next;
                    r_valid <= 1'b1;
                    r_wrap  <= w_wrapped;
                end else begin
                    r_cnt   <= r_cnt + CNT_W'(1);
                    r_data  <= ch_data(bus.i_data, r_ptr);
                    r_sel   <= r_ptr;
                    r_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.o_data  = r_data;
    assign bus.o_sel   = r_sel;
    assign bus.o_valid = r_valid;
    assign bus.o_wrap  = r_wrap;

endmodule

// File: tb/tb_mux_scan_n_1.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_n_1
// Directed and randomized stimulus for mux_scan_n_1 (N_CH=8, DW=4, DWELL=2),
// compared every cycle with a behavioural model of the channel selection.
// -----------------------------------------------------------------------------
module tb_mux_scan_n_1;

    localparam int N_CH  = 8;
    localparam int DW    = 4;
    localparam int DWELL = 2;
    localparam int SEL_W = $clog2(N_CH);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mux_scan_n_1_if #(.N_CH(N_CH), .DW(DW)) bus ();

    mux_scan_n_1 #(
        .N_CH  (N_CH),
        .DW    (DW),
        .DWELL (DWELL)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [DW-1:0] m_data;
    int            m_sel;
    logic          m_valid;
    logic          m_wrap;
    bit            m_scan;   // a channel is currently being scanned out
    int            m_ch;     // channel being scanned out
    int            m_left;   // cycles still to show m_ch, including the current one

    function automatic logic [DW-1:0] chan(input logic [N_CH*DW-1:0] d, input int k);
        logic [N_CH*DW-1:0] t;
        t = d >> (k * DW);
        return t[DW-1:0];
    endfunction

    function automatic int lowest_set(input logic [N_CH-1:0] mask);
        for (int k = 0; k < N_CH; k++)
            if (mask[k]) return k;
        return -1;
    endfunction

    function automatic int next_after(input logic [N_CH-1:0] mask, input int from);
        for (int off = 1; off <= N_CH; off++)
            if (mask[(from + off) % N_CH]) return (from + off) % N_CH;
        return -1;
    endfunction

    task automatic model_reset();
        m_data  = '0;
        m_sel   = 0;
        m_valid = 1'b0;
        m_wrap  = 1'b0;
        m_scan  = 1'b0;
        m_ch    = 0;
        m_left  = 0;
    endtask

    // Expected outputs after one rising edge, from the inputs present at that edge.
    task automatic model_edge();
        int nxt;
        m_wrap = 1'b0;
        if (!bus.i_en) begin
            m_valid = 1'b0;
            m_scan  = 1'b0;
`ifndef MUX_SCAN_HOLD_EN
            m_data  = '0;
`endif
        end else if (bus.i_mode == 1'b0) begin
            m_scan  = 1'b0;
            m_sel   = int'(bus.i_sel);
            m_data  = chan(bus.i_data, m_sel);
            m_valid = 1'b1;
        end else if (bus.i_mask == '0) begin
            m_valid = 1'b0;
            m_scan  = 1'b0;
        end else begin
            if (!m_scan) begin
                m_scan = 1'b1;
                m_ch   = lowest_set(bus.i_mask);
                m_left = DWELL;
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    nxt    = next_after(bus.i_mask, m_ch);
                    m_wrap = (nxt <= m_ch);
                    m_ch   = nxt;
                    m_left = DWELL;
                end
            end
            m_sel   = m_ch;
            m_data  = chan(bus.i_data, m_ch);
            m_valid = 1'b1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".data"},  32'(bus.o_data),  32'(m_data));
        check({tag, ".sel"},   32'(bus.o_sel),   32'(m_sel));
        check({tag, ".valid"}, 32'(bus.o_valid), 32'(m_valid));
        check({tag, ".wrap"},  32'(bus.o_wrap),  32'(m_wrap));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    int exp_seq [12] = '{0, 0, 2, 2, 5, 5, 7, 7, 0, 0, 2, 2};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_en   = 1'b0;
        bus.i_mode = 1'b0;
        bus.i_data = '0;
        bus.i_sel  = '0;
        bus.i_mask = '0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        rst_n = 1'b1;

        // Direct mode walk over all channels
        bus.i_en   = 1'b1;
        bus.i_mode = 1'b0;
        bus.i_data = 32'h7654_3210;
        for (int s = 0; s < N_CH; s++) begin
            bus.i_sel = SEL_W'(s);
            cycle("direct");
            check("direct_const", 32'(bus.o_data), 32'(s));
        end

        // Disable after direct mode
        bus.i_en = 1'b0;
        cycle("idle");
`ifdef MUX_SCAN_HOLD_EN
        check("idle_const", 32'(bus.o_data), 32'd7);
`else
        check("idle_const", 32'(bus.o_data), 32'd0);
`endif

        // Scan over mask 1010_0101
        bus.i_en   = 1'b1;
        bus.i_mode = 1'b1;
        bus.i_mask = 8'b1010_0101;
        for (int c = 0; c < 12; c++) begin
            cycle("scan");
            check("scan_seq", 32'(bus.o_sel), 32'(exp_seq[c]));
            check("scan_wrap", 32'(bus.o_wrap), (c == 8) ? 32'd1 : 32'd0);
        end

        // Empty mask, then a single-bit mask
        bus.i_mask = '0;
        repeat (3) cycle("mask0");
        bus.i_mask = 8'b0001_0000;
        for (int c = 0; c < 6; c++) begin
            cycle("mask1");
            check("mask1_sel", 32'(bus.o_sel), 32'd4);
        end

        // Asynchronous reset in the middle of a dwell
        bus.i_mask = 8'b1010_0101;
        repeat (3) cycle("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle("post_rst");
            check("post_rst_seq", 32'(bus.o_sel), 32'(exp_seq[c]));
        end

        // Back-to-back mode switches
        bus.i_data = 32'($urandom);
        bus.i_mode = 1'b0; bus.i_sel = 3'd5; cycle("sw_direct1");
        bus.i_mode = 1'b1;                   cycle("sw_scan1");
        bus.i_mode = 1'b0; bus.i_sel = 3'd3; cycle("sw_direct2");
        bus.i_mode = 1'b1;                   cycle("sw_scan2");
        check("sw_scan2_sel", 32'(bus.o_sel), 32'd0);

        // Randomized operation
        for (int c = 0; c < 400; c++) begin
            bus.i_data = 32'($urandom);
            if ($urandom_range(0, 19) == 0) bus.i_en = ~bus.i_en;
            if (!bus.i_en && $urandom_range(0, 2) == 0) bus.i_en = 1'b1;
            if ($urandom_range(0, 9) == 0) bus.i_mode = ~bus.i_mode;
            bus.i_sel = SEL_W'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0:       bus.i_mask = '0;
                    1:       bus.i_mask = 8'(1 << $urandom_range(0, N_CH - 1));
                    default: bus.i_mask = 8'($urandom);
                endcase
            end
            cycle("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_scan_n_1.md
# mux_scan_n_1

Parametrised, registered N:1 multiplexer with enable. It generalises the fixed 8:1 single-bit select to N channels of DW bits. It adds an autonomous scan mode that steps through a masked subset of channels with a programmable dwell time. It sits between multi-channel sources and single-lane consumers such as display drivers and serial reporters.

## Interface
- N_CH, 8, number of input channels; power of two, ≥2
- DW, 1, bits per channel
- DWELL, 1, cycles each channel is presented in scan mode; ≥1
- SEL_W (localparam), $clog2(N_CH), select width
- i_clk  in  1  single clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_en  in  1  block enable
- i_mode  in  1  0 = direct select, 1 = scan
- i_data  in  N_CH*DW  channel k occupies bits [k*DW +: DW]
- i_sel  in  SEL_W  channel index in direct mode
- i_mask  in  N_CH  scan-eligible channels; bit k = 1 includes channel k
- o_data  out  DW  selected channel data, registered
- o_sel  out  SEL_W  index of the channel currently on o_data
- o_valid  out  1  o_data/o_sel meaningful
- o_wrap  out  1  one-cycle pulse when the scan pointer wraps

## Operation
- FSM states:
  - IDLE: i_en = 0.
  - DIRECT: i_en = 1, i_mode = 0.
  - SCAN: i_en = 1, i_mode = 1.
  - The next state is a pure function of the current-cycle i_en and i_mode, and any state can reach any other in one cycle.
- Reset: state IDLE, ptr 0, dwell counter 0. Outputs o_data = 0, o_sel = 0, o_valid = 0, o_wrap = 0.
- IDLE: o_valid = 0, o_wrap = 0, o_data per Configuration. o_sel and ptr hold.
- DIRECT: o_data ← i_data[i_sel], o_sel ← i_sel, o_valid ← 1. Any i_sel value is legal.
- SCAN:
  - ptr selects the channel. The dwell counter counts 0..DWELL-1.
  - On the terminal dwell count, ptr advances to the next set i_mask bit strictly after ptr, searching circularly, and the dwell counter clears.
  - o_wrap pulses in the cycle the new ptr is ≤ the old ptr, including the single-bit-mask case where ptr stays put.
- SCAN entry from IDLE or DIRECT:
  - ptr loads the first set mask bit at or after index 0, and the dwell counter clears.
  - The first channel is held for the full DWELL cycles.
- Mask all zero in SCAN: o_valid = 0, o_wrap = 0, ptr and dwell counter hold, o_data holds.
- Mask change mid-dwell: takes effect at the next advance. If the current ptr bit is cleared, the channel is still shown until its dwell completes.
- Data is sampled every cycle, so o_data tracks the live value of the selected channel.

## Timing
- Latency is 1 cycle from i_data, i_sel, i_en or i_mode to o_data, o_sel and o_valid.
- In steady scan with m mask bits set, one full scan period is m·DWELL cycles, with exactly one o_wrap per period.
- o_wrap is registered and aligned with the first o_data cycle of the wrapped-to channel.
- Asynchronous reset clears state and outputs immediately, even mid-dwell. Operation restarts on the first clock edge after deassertion.

## Configuration
- MUX_SCAN_HOLD_EN:
  - Defined: in IDLE, o_data and o_sel retain their last values (o_valid still 0).
  - Undefined: in IDLE, o_data is forced to 0 on the next edge, matching classic enable-gated mux behaviour.

## Structure
- Package mux_scan_pkg holds:
  - the state typedef (IDLE, DIRECT, SCAN);
  - the mode constants MODE_DIRECT = 1'b0 and MODE_SCAN = 1'b1.
- Sub-module mux_scan_next_ch: combinational circular find-next-set-bit.
  - Inputs: mask, start index, inclusive flag.
  - Outputs: next index, found, wrapped.
  - It is instantiated once and used for both the advance and the entry search.

## Test plan
- Reset, then i_en = 1, i_mode = 0, DW = 4, i_data = 0x76543210, i_sel stepping 0→7 → o_data = 0..7, each one cycle after i_sel, with o_valid = 1.
- Direct mode, then i_en = 0 → o_valid = 0. o_data = 0 without the macro; o_data holds at 7 with MUX_SCAN_HOLD_EN.
- SCAN, DWELL = 2, i_mask = 8'b1010_0101 → o_sel sequence 0,0,2,2,5,5,7,7,0,… and o_wrap = 1 in the first cycle of each return to 0.
- SCAN, i_mask = 0 → o_valid = 0 and no o_wrap. Then i_mask = 8'b0001_0000 → o_sel = 4 steady, with o_wrap every DWELL cycles.
- i_rst_n pulsed low mid-dwell in SCAN → outputs 0 immediately. After release, scan restarts at the lowest set mask bit with a full dwell.
- Switch DIRECT→SCAN→DIRECT on consecutive cycles → each mode's output appears exactly one cycle after the mode input changes, with no stale ptr leakage.
